// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - I2S slave receiver: oversampled bus capture, MSB-first deserialiser
// Emits one left/right sample pair per frame with a single-cycle valid strobe.
module i2s_receiver #(
  parameter int SAMPLE_BITS = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_SCLK,
  input  logic                   i_LRCLK,
  input  logic                   i_SDIN,
  output logic [SAMPLE_BITS-1:0] o_Left_Sample,
  output logic [SAMPLE_BITS-1:0] o_Right_Sample,
  output logic                   o_Sample_Valid,
  output logic                   o_Frame_Err,
  output logic                   o_Locked
);

  localparam int CW = $clog2(SAMPLE_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(SAMPLE_BITS);

  typedef enum logic [1:0] {UNLOCKED, LEFT, RIGHT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, lr_sync, sd_sync;
  logic                   sclk_prev;
  logic                   sclk_s, ws, sd, tick, boundary;

  state_t                 state;
  logic                   ws_d, ws_d_prev;
  logic [CW-1:0]          cnt;
  logic [SAMPLE_BITS-1:0] shift, left_hold;
  logic                   left_ok;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sclk_sync <= '0;
      lr_sync   <= '0;
      sd_sync   <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_SCLK};
      lr_sync   <= {lr_sync[SYNC_STAGES-2:0], i_LRCLK};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0], i_SDIN};
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign ws       = lr_sync[SYNC_STAGES-1];
  assign sd       = sd_sync[SYNC_STAGES-1];
  assign tick     = sclk_s & ~sclk_prev;
  // WS leads data by one bit, so the channel of this tick's bit is the delayed ws
  assign boundary = ws_d ^ ws_d_prev;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state          <= UNLOCKED;
      ws_d           <= 1'b0;
      ws_d_prev      <= 1'b0;
      cnt            <= '0;
      shift          <= '0;
      left_hold      <= '0;
      left_ok        <= 1'b0;
      o_Left_Sample  <= '0;
      o_Right_Sample <= '0;
      o_Sample_Valid <= 1'b0;
      o_Frame_Err    <= 1'b0;
      o_Locked       <= 1'b0;
    end else begin
      o_Sample_Valid <= 1'b0;
      o_Frame_Err    <= 1'b0;
      if (tick) begin
        ws_d      <= ws;
        ws_d_prev <= ws_d;
        if (boundary) begin
          cnt   <= CW'(1);
          shift <= {{(SAMPLE_BITS-1){1'b0}}, sd};
          case (state)
            UNLOCKED: begin
              if (!ws_d) begin
                state    <= LEFT;
                o_Locked <= 1'b1;
              end
            end
            LEFT: begin
              state <= RIGHT;
              if (cnt == FULL) begin
                left_hold <= shift;
                left_ok   <= 1'b1;
              end else begin
                o_Frame_Err <= 1'b1;
                left_ok     <= 1'b0;
              end
            end
            RIGHT: begin
              state   <= LEFT;
              left_ok <= 1'b0;
              if (cnt != FULL) begin
                o_Frame_Err <= 1'b1;
              end else if (left_ok) begin
                o_Left_Sample  <= left_hold;
                o_Right_Sample <= shift;
                o_Sample_Valid <= 1'b1;
              end
            end
            default: state <= UNLOCKED;
          endcase
        end else if (cnt < FULL) begin
          // bits past SAMPLE_BITS in a long slot are dropped silently
          shift <= {shift[SAMPLE_BITS-2:0], sd};
          cnt   <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// tb/tb_i2s_receiver.sv - directed self-checking bench for i2s_receiver
// Bus driven at SCLK = clk/16 with standard one-bit WS lead.
module tb_i2s_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        lrclk = 1'b1;
  logic        sdin = 1'b0;
  logic [15:0] left_s, right_s;
  logic        valid, err, locked;

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int vbase, ebase;

  i2s_receiver #(.SAMPLE_BITS(16), .SYNC_STAGES(2)) dut (
    .i_Clk          (clk),
    .i_Reset        (rst),
    .i_SCLK         (sclk),
    .i_LRCLK        (lrclk),
    .i_SDIN         (sdin),
    .o_Left_Sample  (left_s),
    .o_Right_Sample (right_s),
    .o_Sample_Valid (valid),
    .o_Frame_Err    (err),
    .o_Locked       (locked)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) valid_cnt++;
    if (err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one channel slot; lead=1 flips WS on the last bit so the next slot starts a new word
  task automatic send_word(input logic ch, input int nbits, input logic [31:0] val, input bit lead);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sclk  = 1'b0;
      lrclk = (lead && i == nbits - 1) ? ~ch : ch;
      sdin  = val[nbits-1-i];
      repeat (8) @(negedge clk);
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  initial begin
    // 1: reset held while bus toggles
    rst = 1'b1;
    send_word(1'b0, 16, 32'hA5C3, 1'b1);
    send_word(1'b1, 16, 32'h1234, 1'b1);
    check("rst_left", {16'h0, left_s}, 32'h0);
    check("rst_right", {16'h0, right_s}, 32'h0);
    check("rst_locked", {31'h0, locked}, 32'h0);
    check("rst_valid_cnt", valid_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);

    // 2: lock at first left start, three A5C3/1234 frames
    rst = 1'b0;
    vbase = valid_cnt; ebase = err_cnt;
    send_word(1'b1, 16, 32'h0000, 1'b1);
    check("prelock_locked", {31'h0, locked}, 32'h0);
    for (int f = 0; f < 3; f++) begin
      send_word(1'b0, 16, 32'hA5C3, 1'b1);
      check("t2_locked", {31'h0, locked}, 32'h1);
      check("t2_valid_cnt", valid_cnt - vbase, f);
      check("t2_left", {16'h0, left_s}, (f == 0) ? 32'h0 : 32'hA5C3);
      check("t2_right", {16'h0, right_s}, (f == 0) ? 32'h0 : 32'h1234);
      send_word(1'b1, 16, 32'h1234, 1'b1);
    end
    send_word(1'b0, 16, 32'hA5C3, 1'b1);
    check("t2_valid_total", valid_cnt - vbase, 3);
    check("t2_err", err_cnt - ebase, 0);

    // 3: reset released mid right word
    send_word(1'b1, 16, 32'h1234, 1'b1);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("t3_rst_left", {16'h0, left_s}, 32'h0);
    check("t3_rst_locked", {31'h0, locked}, 32'h0);
    send_word(1'b0, 16, 32'hFFFF, 1'b1);
    send_word(1'b1, 8, 32'h12, 1'b0);
    rst = 1'b0;
    vbase = valid_cnt; ebase = err_cnt;
    send_word(1'b1, 8, 32'h34, 1'b1);
    check("t3_unlocked", {31'h0, locked}, 32'h0);
    send_word(1'b0, 16, 32'h1111, 1'b1);
    check("t3_locked", {31'h0, locked}, 32'h1);
    check("t3_no_valid", valid_cnt - vbase, 0);
    check("t3_left_hold0", {16'h0, left_s}, 32'h0);
    check("t3_right_hold0", {16'h0, right_s}, 32'h0);
    send_word(1'b1, 16, 32'h2222, 1'b1);
    send_word(1'b0, 16, 32'h3333, 1'b1);
    check("t3_valid", valid_cnt - vbase, 1);
    check("t3_left", {16'h0, left_s}, 32'h1111);
    check("t3_right", {16'h0, right_s}, 32'h2222);
    send_word(1'b1, 16, 32'h4444, 1'b1);

    // 4: 24-bit slots truncate to top 16 bits
    send_word(1'b0, 24, 32'h800001, 1'b1);
    check("t4_prev_left", {16'h0, left_s}, 32'h3333);
    check("t4_prev_right", {16'h0, right_s}, 32'h4444);
    send_word(1'b1, 24, 32'h7FFFFE, 1'b1);
    send_word(1'b0, 16, 32'h5555, 1'b1);
    check("t4_left", {16'h0, left_s}, 32'h8000);
    check("t4_right", {16'h0, right_s}, 32'h7FFF);
    check("t4_valid", valid_cnt - vbase, 3);
    check("t4_err", err_cnt - ebase, 0);

    // 5: short 12-bit left slot
    send_word(1'b1, 16, 32'h6666, 1'b1);
    send_word(1'b0, 12, 32'hABC, 1'b1);
    check("t5_pre_left", {16'h0, left_s}, 32'h5555);
    vbase = valid_cnt; ebase = err_cnt;
    send_word(1'b1, 16, 32'h7777, 1'b1);
    check("t5_err", err_cnt - ebase, 1);
    send_word(1'b0, 16, 32'h8888, 1'b1);
    check("t5_no_valid", valid_cnt - vbase, 0);
    check("t5_err_once", err_cnt - ebase, 1);
    check("t5_hold_left", {16'h0, left_s}, 32'h5555);
    check("t5_hold_right", {16'h0, right_s}, 32'h6666);
    send_word(1'b1, 16, 32'h9999, 1'b1);
    send_word(1'b0, 8, 32'hAB, 1'b0);
    check("t5_valid", valid_cnt - vbase, 1);
    check("t5_left", {16'h0, left_s}, 32'h8888);
    check("t5_right", {16'h0, right_s}, 32'h9999);

    // 6: reset pulse mid left word
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_left0", {16'h0, left_s}, 32'h0);
    check("t6_right0", {16'h0, right_s}, 32'h0);
    check("t6_locked0", {31'h0, locked}, 32'h0);
    vbase = valid_cnt; ebase = err_cnt;
    send_word(1'b0, 8, 32'hCD, 1'b1);
    send_word(1'b1, 16, 32'h2468, 1'b1);
    check("t6_still_unlocked", {31'h0, locked}, 32'h0);
    send_word(1'b0, 16, 32'h1357, 1'b1);
    check("t6_relocked", {31'h0, locked}, 32'h1);
    send_word(1'b1, 16, 32'h9BDF, 1'b1);
    send_word(1'b0, 16, 32'h0000, 1'b1);
    check("t6_valid", valid_cnt - vbase, 1);
    check("t6_err", err_cnt - ebase, 0);
    check("t6_left", {16'h0, left_s}, 32'h1357);
    check("t6_right", {16'h0, right_s}, 32'h9BDF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
